snake_head_ctrl: RTL and testbench

Upstream neighbour of the apple generator: it owns the snake head position and drives `snakehead_x`/`snakehead_y`. It latches player direction buttons, advances the head one grid cell per move tick, detects apple, wall and border collisions, and keeps the score. It consumes the apple generator's `newapple_x`/`newapple_y` and the shared wall position.

---
 rtl/snake_pkg.sv | 41 ++++
 rtl/move_tick_gen.sv | 41 ++++
 rtl/snake_head_ctrl.sv | 192 +++++++++++++++++++
 tb/tb_snake_head_ctrl.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/snake_pkg.sv
// Shared grid and direction definitions for the snake head and apple generator.
// Latency: none (types, constants and a pure helper function only).
// Backpressure: not applicable.
package snake_pkg;

  typedef enum logic [1:0] {
    UP    = 2'd0,
    DOWN  = 2'd1,
    LEFT  = 2'd2,
    RIGHT = 2'd3
  } dir_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    OVER = 2'd2
  } state_t;

  localparam int          COORD_W  = 11;
  localparam logic [10:0] MIN_X    = 11'd16;
  localparam logic [10:0] MAX_X    = 11'd1392;
  localparam logic [10:0] MIN_Y    = 11'd16;
  localparam logic [10:0] MAX_Y    = 11'd848;
  localparam logic [10:0] START_X  = 11'd400;
  localparam logic [10:0] START_Y  = 11'd432;
  localparam int          DEF_STEP = 32;

  // True when b points straight back along a (a 180-degree turn).
  function automatic logic is_opposite(input dir_t a, input dir_t b);
    logic opp;
    case (a)
      UP:      opp = (b == DOWN);
      DOWN:    opp = (b == UP);
      LEFT:    opp = (b == RIGHT);
      RIGHT:   opp = (b == LEFT);
      default: opp = 1'b0;
    endcase
    return opp;
  endfunction

endpackage

// File: rtl/move_tick_gen.sv
// Move-rate divider: counts 0..TICK_DIV-1 while enabled and flags the terminal count.
// Latency: tick is combinational from the count register; it is high in the cycle before the wrap edge.
// Backpressure: none; clear has priority over enable and holds no state beyond the count.
module move_tick_gen #(
  parameter int TICK_DIV = 25_000_000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic enable,
  input  logic clear,
  output logic tick
);

  localparam int            CW   = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  // Next count: clear wins, otherwise count up and wrap at the terminal value.
  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (enable) begin
      cnt_d = (cnt_q == LAST) ? '0 : cnt_q + CW'(1);
    end
  end

  // Count register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tick = enable && !clear && (cnt_q == LAST);

endmodule

// File: rtl/snake_head_ctrl.sv
// Snake head controller: latches direction buttons, steps the head on each move tick, detects apple/wall/border hits, keeps score.
// Latency: head, move_tick, eat, score and game_over all update on the terminal-count edge; no input reaches an output combinationally.
// Backpressure: none; inputs are sampled every cycle. Define SNAKE_WRAP_EN to wrap at the borders instead of ending the game.
module snake_head_ctrl
  import snake_pkg::*;
#(
  parameter int TICK_DIV = 25_000_000,
  parameter int STEP     = DEF_STEP
) (
  input  logic        clk,
  input  logic        btnrst,
  input  logic        btn_up,
  input  logic        btn_down,
  input  logic        btn_left,
  input  logic        btn_right,
  input  logic        start,
  input  logic [10:0] apple_x,
  input  logic [10:0] apple_y,
  input  logic [10:0] wallpos_x,
  input  logic [10:0] wallpos_y,
  output logic [10:0] snakehead_x,
  output logic [10:0] snakehead_y,
  output logic        move_tick,
  output logic        eat,
  output logic [7:0]  score,
  output logic        game_over
);

  localparam logic signed [11:0] STEP_S = 12'(STEP);
  localparam logic signed [11:0] MIN_XS = $signed({1'b0, MIN_X});
  localparam logic signed [11:0] MAX_XS = $signed({1'b0, MAX_X});
  localparam logic signed [11:0] MIN_YS = $signed({1'b0, MIN_Y});
  localparam logic signed [11:0] MAX_YS = $signed({1'b0, MAX_Y});

  state_t      state_q, state_d;
  dir_t        dir_q, dir_d;
  dir_t        pend_q, pend_d;
  logic [10:0] head_x_q, head_x_d;
  logic [10:0] head_y_q, head_y_d;
  logic [7:0]  score_q, score_d;
  logic        eat_q, eat_d;
  logic        tick_q, tick_d;
  logic        over_q, over_d;

  logic        step_tc;
  logic        tick_en;
  logic        tick_clr;
  logic        btn_any;
  dir_t        btn_dir;
  dir_t        ref_dir;

  logic signed [11:0] hx_s, hy_s, nx_s, ny_s;
  logic [10:0] next_x, next_y;
  logic        border_hit, wall_hit, apple_hit, collide;

  // Counter runs only in RUN and restarts from zero on the edge that enters RUN.
  assign tick_en  = (state_q == RUN);
  assign tick_clr = start && (state_q != RUN);

  move_tick_gen #(
    .TICK_DIV (TICK_DIV)
  ) u_tick (
    .clk    (clk),
    .rst_n  (btnrst),
    .enable (tick_en),
    .clear  (tick_clr),
    .tick   (step_tc)
  );

  // Button priority encoder: up > down > left > right.
  always_comb begin
    btn_any = 1'b1;
    btn_dir = RIGHT;
    if (btn_up) begin
      btn_dir = UP;
    end else if (btn_down) begin
      btn_dir = DOWN;
    end else if (btn_left) begin
      btn_dir = LEFT;
    end else if (btn_right) begin
      btn_dir = RIGHT;
    end else begin
      btn_any = 1'b0;
    end
  end

  // Candidate next cell along the direction that commits on this tick, plus hit detection.
  always_comb begin
    hx_s = $signed({1'b0, head_x_q});
    hy_s = $signed({1'b0, head_y_q});
    nx_s = hx_s;
    ny_s = hy_s;
    case (pend_q)
      UP:      ny_s = hy_s - STEP_S;
      DOWN:    ny_s = hy_s + STEP_S;
      LEFT:    nx_s = hx_s - STEP_S;
      default: nx_s = hx_s + STEP_S;
    endcase
`ifdef SNAKE_WRAP_EN
    border_hit = 1'b0;
    next_x = (nx_s < MIN_XS) ? MAX_X : (nx_s > MAX_XS) ? MIN_X : nx_s[10:0];
    next_y = (ny_s < MIN_YS) ? MAX_Y : (ny_s > MAX_YS) ? MIN_Y : ny_s[10:0];
`else
    border_hit = (nx_s < MIN_XS) || (nx_s > MAX_XS) || (ny_s < MIN_YS) || (ny_s > MAX_YS);
    next_x = nx_s[10:0];
    next_y = ny_s[10:0];
`endif
    wall_hit  = (next_x == wallpos_x) && (next_y == wallpos_y);
    apple_hit = (next_x == apple_x) && (next_y == apple_y);
    collide   = border_hit || wall_hit;
  end

  // Game FSM next-state: start reloads, ticks step the head, collisions hold the head and end the game.
  always_comb begin
    state_d  = state_q;
    dir_d    = dir_q;
    pend_d   = pend_q;
    head_x_d = head_x_q;
    head_y_d = head_y_q;
    score_d  = score_q;
    eat_d    = 1'b0;
    tick_d   = 1'b0;
    // On a tick the pending direction becomes committed, so reversal is judged against it.
    ref_dir  = step_tc ? pend_q : dir_q;
    case (state_q)
      IDLE, OVER: begin
        if (start) begin
          state_d  = RUN;
          head_x_d = START_X;
          head_y_d = START_Y;
          score_d  = 8'd0;
        end
      end
      RUN: begin
        if (btn_any && !is_opposite(ref_dir, btn_dir)) begin
          pend_d = btn_dir;
        end
        if (step_tc) begin
          tick_d = 1'b1;
          dir_d  = pend_q;
          if (collide) begin
            state_d = OVER;
          end else begin
            head_x_d = next_x;
            head_y_d = next_y;
            if (apple_hit) begin
              eat_d = 1'b1;
              if (score_q != 8'hFF) begin
                score_d = score_q + 8'd1;
              end
            end
          end
        end
      end
      default: state_d = IDLE;
    endcase
    over_d = (state_d == OVER);
  end

  // State and registered outputs.
  always_ff @(posedge clk or negedge btnrst) begin
    if (!btnrst) begin
      state_q  <= IDLE;
      dir_q    <= RIGHT;
      pend_q   <= RIGHT;
      head_x_q <= START_X;
      head_y_q <= START_Y;
      score_q  <= 8'd0;
      eat_q    <= 1'b0;
      tick_q   <= 1'b0;
      over_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      dir_q    <= dir_d;
      pend_q   <= pend_d;
      head_x_q <= head_x_d;
      head_y_q <= head_y_d;
      score_q  <= score_d;
      eat_q    <= eat_d;
      tick_q   <= tick_d;
      over_q   <= over_d;
    end
  end

  assign snakehead_x = head_x_q;
  assign snakehead_y = head_y_q;
  assign move_tick   = tick_q;
  assign eat         = eat_q;
  assign score       = score_q;
  assign game_over   = over_q;

endmodule

// File: tb/tb_snake_head_ctrl.sv
// Bench for snake_head_ctrl with a four-cycle move tick.
// Expected head/eat/score/game_over per step are queued by the stimulus and checked on each move_tick.
// Directed sequences: start, reversal, priority, eat, wall-over-apple, border, saturation, async reset.
module tb_snake_head_ctrl;

  localparam int TDIV = 4;
  localparam int STP  = 32;

  logic        clk = 1'b0;
  logic        btnrst = 1'b1;
  logic        btn_up = 1'b0, btn_down = 1'b0, btn_left = 1'b0, btn_right = 1'b0;
  logic        start = 1'b0;
  logic [10:0] apple_x = 11'd16, apple_y = 11'd16;
  logic [10:0] wallpos_x = 11'd16, wallpos_y = 11'd848;
  logic [10:0] snakehead_x, snakehead_y;
  logic        move_tick, eat, game_over;
  logic [7:0]  score;

  always #5 clk = ~clk;

  snake_head_ctrl #(
    .TICK_DIV (TDIV),
    .STEP     (STP)
  ) dut (
    .clk         (clk),
    .btnrst      (btnrst),
    .btn_up      (btn_up),
    .btn_down    (btn_down),
    .btn_left    (btn_left),
    .btn_right   (btn_right),
    .start       (start),
    .apple_x     (apple_x),
    .apple_y     (apple_y),
    .wallpos_x   (wallpos_x),
    .wallpos_y   (wallpos_y),
    .snakehead_x (snakehead_x),
    .snakehead_y (snakehead_y),
    .move_tick   (move_tick),
    .eat         (eat),
    .score       (score),
    .game_over   (game_over)
  );

  typedef struct packed {
    logic [10:0] x;
    logic [10:0] y;
    logic        e;
    logic [7:0]  s;
    logic        g;
  } exp_t;

  exp_t exp_q[$];
  int   tests = 0;
  int   fails = 0;
  int   tick_no = 0;
  exp_t mon_e, mon_a;

  // Monitor: every move_tick pops one expected step; eat must only appear with move_tick.
  always @(negedge clk) begin
    if (eat) begin
      tests++;
      if (!move_tick) begin
        fails++;
        $display("FAIL eat_without_tick: eat=1 move_tick=0, required move_tick=1");
      end
    end
    if (move_tick) begin
      tick_no++;
      mon_a = '{x: snakehead_x, y: snakehead_y, e: eat, s: score, g: game_over};
      tests++;
      if (exp_q.size() == 0) begin
        fails++;
        $display("FAIL unexpected_tick%0d: head=(%0d,%0d) while no step was expected",
                 tick_no, snakehead_x, snakehead_y);
      end else begin
        mon_e = exp_q.pop_front();
        if (mon_a !== mon_e) begin
          fails++;
          $display("FAIL tick%0d: got head=(%0d,%0d) eat=%0d score=%0d over=%0d, expected head=(%0d,%0d) eat=%0d score=%0d over=%0d",
                   tick_no, mon_a.x, mon_a.y, mon_a.e, mon_a.s, mon_a.g,
                   mon_e.x, mon_e.y, mon_e.e, mon_e.s, mon_e.g);
        end
      end
    end
  end

  task automatic chk(input string name, input int act, input int req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", name, act, req);
    end
  endtask

  task automatic expect_step(input int x, input int y, input int e, input int s, input int g);
    exp_t t;
    t.x = 11'(x);
    t.y = 11'(y);
    t.e = 1'(e);
    t.s = 8'(s);
    t.g = 1'(g);
    exp_q.push_back(t);
  endtask

  // Wait (bounded) for the negedge at which move_tick is high; n = negedges waited.
  task automatic wait_tick(output int n);
    bit seen;
    seen = 1'b0;
    n = 0;
    for (int i = 0; i < 40; i++) begin
      if (!seen) begin
        @(negedge clk);
        n++;
        seen = move_tick;
      end
    end
    if (!seen) begin
      tests++;
      fails++;
      $display("FAIL tick_timeout: no move_tick after %0d cycles, expected one", n);
    end
  endtask

  task automatic set_btn(input logic u, input logic d, input logic l, input logic r);
    btn_up = u;
    btn_down = d;
    btn_left = l;
    btn_right = r;
  endtask

  task automatic start_pulse();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  int n;
  int hx, hy, nx, ny, seg, sc;

  initial begin
    // Reset state
    #2 btnrst = 1'b0;
    #1;
    chk("rst_head_x", snakehead_x, 400);
    chk("rst_head_y", snakehead_y, 432);
    chk("rst_score", score, 0);
    chk("rst_eat", eat, 0);
    chk("rst_move_tick", move_tick, 0);
    chk("rst_game_over", game_over, 0);
    @(negedge clk);
    @(negedge clk);
    btnrst = 1'b1;
    // IDLE: no ticks, buttons ignored
    btn_up = 1'b1;
    repeat (6) @(negedge clk);
    btn_up = 1'b0;
    chk("idle_hold_y", snakehead_y, 432);

    // Start and first step on the 4th RUN cycle
    start_pulse();
    expect_step(432, 432, 0, 0, 0);
    wait_tick(n);
    chk("first_step_cycles", n, 4);

    // Reversal request ignored; start in RUN ignored (period unchanged, no reload)
    set_btn(0, 0, 1, 0);
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    expect_step(464, 432, 0, 0, 0);
    wait_tick(n);
    chk("tick_period_start_in_run", n + 2, 4);

    // Turn up
    set_btn(1, 0, 0, 0);
    expect_step(464, 400, 0, 0, 0);
    wait_tick(n);
    chk("tick_period", n, 4);

    // Up and right together: up wins
    set_btn(1, 0, 0, 1);
    expect_step(464, 368, 0, 0, 0);
    wait_tick(n);

    // Turn right, then eat
    set_btn(0, 0, 0, 1);
    expect_step(496, 368, 0, 0, 0);
    wait_tick(n);
    apple_x = 11'd528;
    apple_y = 11'd368;
    expect_step(528, 368, 1, 1, 0);
    wait_tick(n);
    @(negedge clk);
    chk("eat_one_cycle", eat, 0);
    chk("score_after_eat", score, 1);

    // Wall and apple on the same cell: wall wins
    wallpos_x = 11'd560;
    wallpos_y = 11'd368;
    apple_x = 11'd560;
    apple_y = 11'd368;
    expect_step(528, 368, 0, 1, 1);
    wait_tick(n);
    set_btn(0, 1, 0, 0);
    repeat (8) @(negedge clk);
    chk("over_game_over", game_over, 1);
    chk("over_hold_x", snakehead_x, 528);
    chk("over_hold_y", snakehead_y, 368);

    // Recovery from OVER
    set_btn(0, 0, 0, 0);
    wallpos_x = 11'd16;
    wallpos_y = 11'd848;
    apple_x = 11'd16;
    apple_y = 11'd16;
    start_pulse();
    chk("restart_x", snakehead_x, 400);
    chk("restart_y", snakehead_y, 432);
    chk("restart_score", score, 0);
    chk("restart_game_over", game_over, 0);

    // Run right to the border
    for (int i = 0; i < 31; i++) begin
      expect_step(400 + STP * (i + 1), 432, 0, 0, 0);
      wait_tick(n);
    end
`ifdef SNAKE_WRAP_EN
    expect_step(16, 432, 0, 0, 0);
    wait_tick(n);
    hx = 16;
    hy = 432;
`else
    expect_step(1392, 432, 0, 0, 1);
    wait_tick(n);
    repeat (6) @(negedge clk);
    chk("border_over", game_over, 1);
    start_pulse();
    chk("border_restart_x", snakehead_x, 400);
    hx = 400;
    hy = 432;
`endif

    // Eat on every step around a square until the score saturates
    for (int i = 0; i < 258; i++) begin
      seg = (i / 4) % 4;
      nx = hx;
      ny = hy;
      case (seg)
        0: begin nx = hx + STP; set_btn(0, 0, 0, 1); end
        1: begin ny = hy + STP; set_btn(0, 1, 0, 0); end
        2: begin nx = hx - STP; set_btn(0, 0, 1, 0); end
        default: begin ny = hy - STP; set_btn(1, 0, 0, 0); end
      endcase
      apple_x = 11'(nx);
      apple_y = 11'(ny);
      sc = (i + 1 > 255) ? 255 : i + 1;
      expect_step(nx, ny, 1, sc, 0);
      wait_tick(n);
      hx = nx;
      hy = ny;
    end
    chk("score_saturated", score, 255);

    // Asynchronous reset mid-count
    set_btn(0, 0, 0, 0);
    @(negedge clk);
    #2 btnrst = 1'b0;
    #1;
    chk("arst_head_x", snakehead_x, 400);
    chk("arst_head_y", snakehead_y, 432);
    chk("arst_score", score, 0);
    chk("arst_eat", eat, 0);
    chk("arst_move_tick", move_tick, 0);
    chk("arst_game_over", game_over, 0);
    #6 btnrst = 1'b1;
    repeat (8) @(negedge clk);
    chk("arst_idle_x", snakehead_x, 400);
    chk("scoreboard_drained", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
